// File: rtl/relu_layer_ctrl.sv
// relu_layer_ctrl
//   Sequences one activation pass over an IMG_W x IMG_H feature map. It reads the
//   conv-output buffer in raster order, passes each word through an external
//   1-cycle relu stage, and queues the results in a small output FIFO. The FIFO
//   drains to the pool-input buffer under valid/ready handshaking. Reads are only
//   issued when the FIFO is guaranteed to have room for them. The relu stage cannot
//   stall, so this credit check is what makes downstream backpressure safe.
//
//   Optional feature: define RELU_CTRL_STALL_CNT_EN to add the stall_cnt output.
//   stall_cnt is a saturating count of busy cycles in which the FIFO head was
//   blocked by wr_ready.
//
// Ports
//   clk        clock, rising edge
//   rstn       synchronous reset, active-high (1 = reset)
//   start      1-cycle pulse that begins a pass; ignored while busy
//   busy       pass in progress (RUN / DRAIN / DONE)
//   done       1-cycle pulse after the last output handshake
//   rd_en      conv-buffer read strobe
//   rd_addr    conv-buffer address; data returns one cycle later
//   rd_data    conv-buffer read data
//   relu_en    relu stage enable (rd_en delayed one cycle)
//   relu_data  relu stage input (rd_data passed straight through)
//   relu_q_en  relu stage result strobe
//   relu_q     relu stage result
//   wr_valid   pool-buffer write request (FIFO not empty)
//   wr_ready   downstream accept
//   wr_addr    raster index of the FIFO head entry
//   wr_data    FIFO head data
//   stall_cnt  (RELU_CTRL_STALL_CNT_EN only) saturating backpressure cycle count
module relu_layer_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int INPUT_NUM  = 6,
  parameter int WDP        = 9,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [WDP*INPUT_NUM-1:0] rd_data,
  output logic                     relu_en,
  output logic [WDP*INPUT_NUM-1:0] relu_data,
  input  logic                     relu_q_en,
  input  logic [WDP*INPUT_NUM-1:0] relu_q,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WDP*INPUT_NUM-1:0] wr_data
`ifdef RELU_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int DW    = WDP * INPUT_NUM;
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FC_W-1:0]  FULL_C   = FC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, push_cnt;
  logic [1:0]       inflight;
  logic [FC_W-1:0]  fifo_count;
  logic [PTR_W-1:0] head, tail;
  logic [DW-1:0]     data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] tag_mem  [FIFO_DEPTH];

  logic start_acc, push, pop, wr_last, credit_ok;

  assign start_acc = start && (state == S_IDLE);
  // A relu result arriving outside a pass belongs to a pass aborted by reset.
  assign push      = relu_q_en && (state != S_IDLE);
  assign pop       = wr_valid && wr_ready;
  // Leave DRAIN on the cycle of the final pop so done follows it directly.
  assign wr_last   = (wr_cnt == N_C) || (pop && (wr_cnt == LAST_C));
  // Every issued read must find a FIFO slot when it returns two cycles later.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    if (rstn) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)           state_nxt = S_RUN;
      S_RUN:   if (rd_cnt == N_C)   state_nxt = S_DRAIN;
      S_DRAIN: if (wr_last)         state_nxt = S_DONE;
      S_DONE:                       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    rd_en = (state == S_RUN) && (rd_cnt != N_C) && credit_ok;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rstn) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      push_cnt <= '0;
      inflight <= '0;
      relu_en  <= 1'b0;
    end else begin
      relu_en <= rd_en;
      if (start_acc || (state == S_DONE)) begin
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        push_cnt <= '0;
        inflight <= '0;
      end else begin
        if (rd_en) rd_cnt   <= rd_cnt + CNT_W'(1);
        if (pop)   wr_cnt   <= wr_cnt + CNT_W'(1);
        if (push)  push_cnt <= push_cnt + CNT_W'(1);
        case ({rd_en, push})
          2'b10:   inflight <= inflight + 2'd1;
          2'b01:   inflight <= inflight - 2'd1;
          default: inflight <= inflight;
        endcase
      end
    end
  end

  assign rd_addr   = ADDR_W'(rd_cnt);
  assign relu_data = rd_data;

  // ---------------------------------------------------------------- output FIFO
  always_ff @(posedge clk) begin
    if (rstn) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) tail <= (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);
      if (pop)  head <= (head == PTR_LAST) ? '0 : head + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FC_W'(1);
        2'b01:   fifo_count <= fifo_count - FC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only observed after it is written,
  // and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail] <= relu_q;
      tag_mem[tail]  <= ADDR_W'(push_cnt);
    end
  end

  assign wr_valid = (fifo_count != '0);
  assign wr_data  = wr_valid ? data_mem[head] : '0;
  assign wr_addr  = wr_valid ? tag_mem[head]  : '0;

`ifdef RELU_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rstn || start_acc)
      stall_cnt <= '0;
    else if (busy && wr_valid && !wr_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rstn)
    !(push && (fifo_count == FULL_C)));

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// tb_relu_layer_ctrl
//   Self-checking bench for relu_layer_ctrl. Three instances (4x4, 8x8, 1x1 maps)
//   share one clock and reset. Each instance has a conv-buffer model and a 1-cycle
//   relu model around it. Whole passes come from a vector table. A hand-written
//   sequence covers the mid-pass reset.
module tb_relu_layer_ctrl;

  localparam int DW = 54;
  localparam int AW = 6;
  localparam int NI = 3;

  typedef struct {
    int g;         // instance: 0=4x4, 1=8x8, 2=1x1
    int mode;      // rd_data pattern
    int rmode;     // wr_ready pattern
    int restart;   // cycle of an extra start pulse (0 = none)
    int first_rd;  // expected cycles, -1 = not checked
    int first_wr;
    int done_cyc;
    int n;         // expected reads and writes
    int probe;     // cycle at which reads-so-far is sampled (0 = none)
    int probe_exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic start[NI], busy[NI], done[NI], rd_en[NI], relu_en[NI];
  logic relu_q_en[NI], wr_valid[NI], wr_ready[NI];
  logic [AW-1:0] rd_addr[NI], wr_addr[NI];
  logic [DW-1:0] rd_data[NI], relu_data[NI], relu_q[NI], wr_data[NI];
`ifdef RELU_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt[NI];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode[NI];

  // monitor state, written only by the monitor process
  int c0[NI], rd_n[NI], wr_n[NI], first_rd[NI], first_wr[NI];
  int done_n[NI], done_at[NI], exp_stall[NI];
  logic hold[NI];
  logic [AW-1:0] hold_a[NI];
  logic [DW-1:0] hold_d[NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // conv-buffer contents
  function automatic logic [DW-1:0] mem_word(int a, int m);
    logic [DW-1:0] w;
    logic [8:0] v;
    w = '0;
    for (int p = 0; p < 6; p++) begin
      case (m)
        0:       v = 9'(a + p);
        1:       v = 9'h100 | 9'(a + p);
        default: v = (p % 2 == 0) ? 9'h07F : (9'h180 | 9'(a));
      endcase
      w[p*9 +: 9] = v;
    end
    return w;
  endfunction

  // behaviour of the relu stage: negative planes clamp to zero
  function automatic logic [DW-1:0] relu_word(logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = d;
    for (int p = 0; p < 6; p++)
      if (d[p*9 + 8]) w[p*9 +: 9] = 9'h000;
    return w;
  endfunction

  // hand-derived expected output word per raster index
  function automatic logic [DW-1:0] exp_word(int idx, int m);
    logic [DW-1:0] w;
    logic [8:0] v;
    w = '0;
    for (int p = 0; p < 6; p++) begin
      case (m)
        0:       v = 9'(idx + p);
        1:       v = 9'h000;
        default: v = (p % 2 == 0) ? 9'h07F : 9'h000;
      endcase
      w[p*9 +: 9] = v;
    end
    return w;
  endfunction

  function automatic logic ready_at(int rmode, int r);
    case (rmode)
      0:       return 1'b1;
      1:       return !(r >= 2 && r < 40);
      default: return (r % 2 == 1);
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 8 : 1);

    relu_layer_ctrl #(
      .IMG_W(S), .IMG_H(S), .INPUT_NUM(6), .WDP(9), .ADDR_W(AW), .FIFO_DEPTH(4)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .relu_en   (relu_en[g]),
      .relu_data (relu_data[g]),
      .relu_q_en (relu_q_en[g]),
      .relu_q    (relu_q[g]),
      .wr_valid  (wr_valid[g]),
      .wr_ready  (wr_ready[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g])
`ifdef RELU_CTRL_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt[g])
`endif
    );

    always @(posedge clk) begin
      if (rd_en[g] === 1'b1) rd_data[g] <= mem_word(int'(rd_addr[g]), mode[g]);
      if (rstn) relu_q_en[g] <= 1'b0;
      else      relu_q_en[g] <= relu_en[g];
      relu_q[g] <= relu_word(relu_data[g]);
    end
  end

  // Monitor: cycle n of a pass is the value seen at the negedge before edge n,
  // where edge 0 is the edge that samples start.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (start[g] === 1'b1 && busy[g] === 1'b0) begin
        c0[g] = cyc;  rd_n[g] = 0;  wr_n[g] = 0;
        first_rd[g] = -1;  first_wr[g] = -1;
        done_n[g] = 0;  done_at[g] = -1;  exp_stall[g] = 0;  hold[g] = 1'b0;
      end else begin
        if (hold[g]) begin
          check("hold_valid", 64'(wr_valid[g]), 64'd1);
          check("hold_addr", 64'(wr_addr[g]), 64'(hold_a[g]));
          check("hold_data", 64'(wr_data[g]), 64'(hold_d[g]));
        end
        if (rd_en[g] === 1'b1) begin
          check("rd_addr_order", 64'(rd_addr[g]), 64'(rd_n[g]));
          if (first_rd[g] < 0) first_rd[g] = cyc - c0[g];
          rd_n[g]++;
        end
        if (wr_valid[g] === 1'b1 && wr_ready[g] === 1'b1) begin
          check("wr_addr_order", 64'(wr_addr[g]), 64'(wr_n[g]));
          check("wr_data", 64'(wr_data[g]), 64'(exp_word(wr_n[g], mode[g])));
          if (first_wr[g] < 0) first_wr[g] = cyc - c0[g];
          wr_n[g]++;
        end
        if (busy[g] === 1'b1 && wr_valid[g] === 1'b1 && wr_ready[g] === 1'b0)
          exp_stall[g]++;
        if (done[g] === 1'b1) begin
          done_n[g]++;
          done_at[g] = cyc - c0[g];
        end
        hold[g]   = (wr_valid[g] === 1'b1) && (wr_ready[g] === 1'b0);
        hold_a[g] = wr_addr[g];
        hold_d[g] = wr_data[g];
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic run_pass(input vec_t v);
    int g, r, probe_val;
    g = v.g;
    probe_val = -1;
    mode[g] = v.mode;
    wr_ready[g] = 1'b1;
    pulse_start(g);
    r = 1;
    while (r < 400 && !(done_n[g] > 0 && r > done_at[g] + 3)) begin
      wr_ready[g] = ready_at(v.rmode, r);
      start[g] = (r == v.restart);
      if (r == v.probe) probe_val = rd_n[g];
      @(posedge clk); #1;
      r++;
    end
    start[g] = 1'b0;
    wr_ready[g] = 1'b1;
    check("done_count", 64'(done_n[g]), 64'd1);
    check("reads", 64'(rd_n[g]), 64'(v.n));
    check("writes", 64'(wr_n[g]), 64'(v.n));
    if (v.first_rd >= 0) check("first_rd_cycle", 64'(first_rd[g]), 64'(v.first_rd));
    if (v.first_wr >= 0) check("first_wr_cycle", 64'(first_wr[g]), 64'(v.first_wr));
    if (v.done_cyc >= 0) check("done_cycle", 64'(done_at[g]), 64'(v.done_cyc));
    if (v.probe > 0) check("reads_under_stall", 64'(probe_val), 64'(v.probe_exp));
`ifdef RELU_CTRL_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt[g]), 64'(exp_stall[g]));
`endif
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_busy", 64'(busy[g]), 64'd0);
    check("rst_done", 64'(done[g]), 64'd0);
    check("rst_rd_en", 64'(rd_en[g]), 64'd0);
    check("rst_rd_addr", 64'(rd_addr[g]), 64'd0);
    check("rst_relu_en", 64'(relu_en[g]), 64'd0);
    check("rst_wr_valid", 64'(wr_valid[g]), 64'd0);
    check("rst_wr_addr", 64'(wr_addr[g]), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    //            g mode rmode restart first_rd first_wr done  n  probe probe_exp
    vecs[0] = '{0, 0, 0, 0, 1, 4,  20, 16, 0,  0};  // baseline, full rate
    vecs[1] = '{0, 1, 0, 0, 1, 4,  20, 16, 0,  0};  // all planes negative
    vecs[2] = '{0, 2, 0, 5, 1, 4,  20, 16, 0,  0};  // mixed planes, start again at 5
    vecs[3] = '{0, 0, 1, 0, 1, 40, 56, 16, 30, 4};  // ready low 2..39
    vecs[4] = '{1, 0, 2, 0, 1, 5,  -1, 64, 0,  0};  // 8x8, ready toggling
    vecs[5] = '{2, 0, 0, 0, 1, 4,  5,  1,  0,  0};  // 1x1 map

    rstn = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      wr_ready[g] = 1'b1;
      mode[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) check_reset_outputs(g);

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    // Mid-pass reset: extra start at cycle 5, reset sampled at edge 8.
    mode[0] = 0;
    pulse_start(0);
    for (int r = 1; r <= 8; r++) begin
      start[0] = (r == 5);
      rstn = (r == 8);
      @(posedge clk); #1;
    end
    start[0] = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_n[0]), 64'd0);
    check("rst_writes_before_abort", 64'(wr_n[0]), 64'd5);
    check("rst_idle_wr_valid", 64'(wr_valid[0]), 64'd0);

    // A fresh pass after the abort completes normally.
    run_pass(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
